// File: rtl/prog_freq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants, channel state type and helpers for the
//               programmable frequency divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Counter/limit width carried by the channel state type.
  localparam int DIV_CNT_W = 16;

  // Limit every channel starts from after reset.
  localparam int DEFAULT_LIMIT = 25;

  // Complete architectural state of one divider channel.
  typedef struct packed {
    logic [DIV_CNT_W-1:0] cnt;
    logic [DIV_CNT_W-1:0] limit;
    logic [DIV_CNT_W-1:0] shadow;
    logic                 pending;
    logic                 q;
  } ch_state_t;

  // Step decode: the step select is an exponent of two.
  function automatic int unsigned step_of(input int unsigned sel);
    return 32'd1 << sel;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_freq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_freq_divider_if
// Description : Limit-update request port (valid/ready) of the divider.
//               master = requester, slave = divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_freq_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = div_pkg::DIV_CNT_W
);
  import div_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic             valid;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] limit;
  logic             ready;

  modport master (output valid, output ch, output limit, input ready);
  modport slave  (input valid, input ch, input limit, output ready);

endinterface
`default_nettype wire

// File: rtl/prog_freq_divider_channel.sv
`default_nettype none
// ============================================================================
// Module      : div_channel
// Description : One divider channel: step accumulator with saturation,
//               compare against limit, output toggle, and a shadow limit
//               register that is committed only at a toggle (or at once
//               while the channel is disabled) so the output never glitches.
//               Optional macro: DIV_TICK_EN adds a one-cycle toggle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module div_channel
  import div_pkg::*;
#(
  parameter int                   STEP_SEL_W  = 2,
  parameter logic [DIV_CNT_W-1:0] RESET_LIMIT = DIV_CNT_W'(DEFAULT_LIMIT)
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  enable,
  input  wire logic [STEP_SEL_W-1:0] step_sel,
  input  wire logic                  wr,
  input  wire logic [DIV_CNT_W-1:0]  wr_limit,
  output logic                       pending,
  output logic                       q
`ifdef DIV_TICK_EN
  ,
  output logic                       tick
`endif
);

  ch_state_t            state;
  ch_state_t            state_next;
  logic [DIV_CNT_W-1:0] step;
  logic [DIV_CNT_W:0]   sum;
  logic                 fire;

  // Next-state: toggle/clear on overflow past limit, otherwise saturating add;
  // shadow commit happens at the toggle or immediately when disabled.
  always_comb begin
    step       = DIV_CNT_W'(step_of(32'(step_sel)));
    sum        = {1'b0, state.cnt} + {1'b0, step};
    fire       = enable && (state.cnt > state.limit);
    state_next = state;

    if (fire) begin
      state_next.q   = ~state.q;
      state_next.cnt = '0;
      if (state.pending) begin
        state_next.limit   = state.shadow;
        state_next.pending = 1'b0;
      end
    end else if (enable) begin
      state_next.cnt = sum[DIV_CNT_W] ? {DIV_CNT_W{1'b1}} : sum[DIV_CNT_W-1:0];
    end else if (state.pending) begin
      state_next.limit   = state.shadow;
      state_next.pending = 1'b0;
    end

    // A write is only accepted while nothing is pending, so it never races
    // the commit above; it always lands after this cycle's toggle decision.
    if (wr) begin
      state_next.shadow  = wr_limit;
      state_next.pending = 1'b1;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '{cnt: '0, limit: RESET_LIMIT, shadow: '0, pending: 1'b0, q: 1'b0};
    end else begin
      state <= state_next;
    end
  end

`ifdef DIV_TICK_EN
  // Strobe aligned with the cycle in which q changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= fire;
    end
  end
`endif

  assign q       = state.q;
  assign pending = state.pending;

endmodule
`default_nettype wire

// File: rtl/prog_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_freq_divider
// Description : Multi-channel programmable frequency divider / square-wave
//               generator with glitch-free limit reprogramming over a
//               valid/ready port.
//               Optional macro: DIV_TICK_EN adds the tick[NUM_CH] output.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_freq_divider
  import div_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = DIV_CNT_W,   // must match the channel state width
  parameter int STEP_SEL_W    = 2,
  parameter int DEFAULT_LIMIT = div_pkg::DEFAULT_LIMIT
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic [NUM_CH-1:0]            enable,
  input  wire logic [NUM_CH*STEP_SEL_W-1:0] step_sel,
  prog_freq_divider_if.slave                cfg,
  output logic [NUM_CH-1:0]                 q
`ifdef DIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]                 tick
`endif
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;

  // Ready reflects the addressed channel; out-of-range indices never match.
  always_comb begin
    cfg.ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg.ch == CH_W'(c)) begin
        cfg.ready = !pending[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c] = cfg.valid && (cfg.ch == CH_W'(c)) && !pending[c];

    div_channel #(
      .STEP_SEL_W  (STEP_SEL_W),
      .RESET_LIMIT (DIV_CNT_W'(DEFAULT_LIMIT))
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable[c]),
      .step_sel (step_sel[c*STEP_SEL_W +: STEP_SEL_W]),
      .wr       (wr[c]),
      .wr_limit (cfg.limit),
      .pending  (pending[c]),
      .q        (q[c])
`ifdef DIV_TICK_EN
      ,
      .tick     (tick[c])
`endif
    );
  end

endmodule
`default_nettype wire
